uart_tx: RTL

Byte-wide UART transmitter. It is the transmit counterpart of the team's one-bit-per-clock UART receiver.
- Accepts bytes over a valid/ready handshake into a one-entry holding register.
- Serialises each byte as start(0), 8 data bits LSB first, then stop bit(s) (1) on txd.
- Sits between the AES result path and the board TX pin.
- The default parameters produce frames the receiver decodes directly, clocked on the same clk.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and FSM state encodings.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick marks the last clk of each serial bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Wrap after the last count, or realign to 0 whenever the caller changes state.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (restart || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter with a one-entry holding register.
// txd and busy are registered and reflect the state the FSM has been in,
// so the line never has a combinational path from any input.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       txd,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       load;
  logic       xfer;
  logic       tick;
  logic       restart;

  assign in_ready = !hold_valid_q;
  assign txd      = txd_q;
  assign busy     = busy_q;
  assign xfer     = in_valid && !hold_valid_q;
  assign restart  = (state_d != state_q);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rstn   (rstn),
    .restart(restart),
    .tick   (tick)
  );

  // Next-state, holding register and registered line/busy values.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    load         = 1'b0;
    txd_d        = 1'b1;

    case (state_q)
      TX_IDLE: begin
        if (hold_valid_q) begin
          load    = 1'b1;
          state_d = TX_START;
        end
      end
      TX_START: begin
        txd_d = 1'b0;
        if (tick) begin
          state_d   = TX_DATA;
          bit_cnt_d = '0;
        end
      end
      TX_DATA: begin
        txd_d = shift_q[0];
        if (tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = TX_STOP;
            stop_cnt_d = 1'b0;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            // Back-to-back frames go straight to a start bit with no idle bit.
            if (hold_valid_q) begin
              load    = 1'b1;
              state_d = TX_START;
            end else begin
              state_d = TX_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // A drain only happens with hold full and a refill only with hold empty,
    // so the two never coincide on one edge.
    if (load) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
    end
    if (xfer) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end

    busy_d = (state_q != TX_IDLE) || hold_valid_q;
  end

  // State and datapath registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= TX_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
    end
  end

endmodule
